// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_wb_sched_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned PEND_W  = 2;
  localparam int unsigned QCNT_W  = 3;
  localparam int unsigned NUM_CNT = 15;

  localparam logic [ADDR_W-1:0] LINK_REG = 4'd14;
  localparam logic [ADDR_W-1:0] PC_REG   = 4'd15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

  // Source index also fixes enqueue order
  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_ALU = 2'd1,
    SRC_LNK = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_sched_fifo.sv
// Write queue: DEPTH entries, up to three in-order pushes and one pop per cycle.
module regfile_wb_sched_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      push_i,
  input  wq_entry_t [NUM_SRC-1:0] push_data_i,
  input  logic                    pop_i,
  output wq_entry_t               head_o,
  output logic                    empty_o,
  output logic [QCNT_W-1:0]       count_o,
  output logic                    ovf_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW    = QCNT_W + 1;

  wq_entry_t          mem_q [DEPTH];
  wq_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [QCNT_W-1:0]  count_q, count_d;
  logic               pop_ok;
  logic [FW-1:0]      free_slots;
  logic [FW-1:0]      n_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Pushes land compacted at consecutive slots; any beyond free space are dropped
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_o      = 1'b0;
    n_push     = '0;
    pop_ok     = pop_i && (count_q != '0);
    free_slots = FW'(DEPTH) - FW'(count_q) + FW'(pop_ok);
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_i[i]) begin
        if (n_push < free_slots) begin
          mem_d[wr_ptr_d] = push_data_i[i];
          wr_ptr_d        = ptr_inc(wr_ptr_d);
          n_push          = n_push + FW'(1);
        end else begin
          ovf_o = 1'b1;
        end
      end
    end
    count_d = count_q + QCNT_W'(n_push) - QCNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file writeback arbiter with ordering queue and pending-write scoreboard.
// Optional forwarding enabled by defining REGFILE_WB_SCHED_FWD_EN.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              lnk_valid,
  input  logic [DATA_W-1:0] lnk_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              stall,
  output logic              hazard,
  output logic [2:0]        fwd_hit,
  output logic [QCNT_W-1:0] q_count,
  output logic              err
);

  logic [NUM_SRC-1:0]      req_v, accept, push;
  wq_entry_t [NUM_SRC-1:0] req_e;
  wq_entry_t               q_head, grant_e;
  logic                    q_empty, q_ovf, pop, grant_v;
  logic [QCNT_W-1:0]       q_cnt;
  logic                    stall_int, drop_err, iss_ok, cnt_err;
  logic [PEND_W-1:0]       pend_q [NUM_CNT];
  logic [PEND_W-1:0]       pend_d [NUM_CNT];
  logic                    err_q, err_d;
  logic [ADDR_W-1:0]       rd_a [3];
  logic                    hazard_c;
  logic [2:0]              fwd_c;

  always_comb begin
    req_v                 = '0;
    req_e                 = '0;
    req_v[int'(SRC_MEM)]  = mem_valid;
    req_v[int'(SRC_ALU)]  = alu_valid;
    req_v[int'(SRC_LNK)]  = lnk_valid;
    req_e[int'(SRC_MEM)]  = '{addr: mem_addr, data: mem_data};
    req_e[int'(SRC_ALU)]  = '{addr: alu_addr, data: alu_data};
    req_e[int'(SRC_LNK)]  = '{addr: LINK_REG, data: lnk_data};
  end

  assign stall_int = (q_cnt >= QCNT_W'(DEPTH - 1));
  assign accept    = req_v & {NUM_SRC{~stall_int}};
  assign drop_err  = stall_int && ((|req_v) || iss_valid);

  // Queue head wins; a direct grant only when empty keeps write order
  always_comb begin
    grant_v = 1'b0;
    grant_e = '0;
    push    = accept;
    pop     = 1'b0;
    if (!q_empty) begin
      grant_v = 1'b1;
      grant_e = q_head;
      pop     = 1'b1;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i] && !grant_v) begin
          grant_v = 1'b1;
          grant_e = req_e[i];
          push[i] = 1'b0;
        end
      end
    end
    if (reset) grant_v = 1'b0;
  end

  regfile_wb_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (req_e),
    .pop_i       (pop),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .count_o     (q_cnt),
    .ovf_o       (q_ovf)
  );

  assign rf_we    = grant_v && (grant_e.addr != PC_REG);
  assign rf_waddr = grant_e.addr;
  assign rf_wdata = grant_e.data;
  assign pc_we    = grant_v && (grant_e.addr == PC_REG);
  assign pc_wdata = grant_e.data;
  assign stall    = stall_int;
  assign q_count  = q_cnt;

  assign iss_ok = iss_valid && !stall_int && (iss_addr != PC_REG);

  // Pending-write counters: issue increments, commit decrements, both cancel
  always_comb begin
    pend_d  = pend_q;
    cnt_err = 1'b0;
    for (int r = 0; r < NUM_CNT; r++) begin
      if (iss_ok && (iss_addr == ADDR_W'(r)) && !(rf_we && (rf_waddr == ADDR_W'(r)))) begin
        if (pend_q[r] == 2'd3) cnt_err = 1'b1;
        else                   pend_d[r] = pend_q[r] + 2'd1;
      end else if (rf_we && (rf_waddr == ADDR_W'(r)) && !(iss_ok && (iss_addr == ADDR_W'(r)))) begin
        if (pend_q[r] == 2'd0) cnt_err = 1'b1;
        else                   pend_d[r] = pend_q[r] - 2'd1;
      end
    end
  end

  assign err_d = err_q | drop_err | q_ovf | cnt_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_CNT; r++) pend_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

  always_comb begin
    rd_a[0]  = rd_addr1;
    rd_a[1]  = rd_addr2;
    rd_a[2]  = rd_addr3;
    hazard_c = 1'b0;
    fwd_c    = '0;
    for (int p = 0; p < 3; p++) begin
      if ((rd_a[p] != PC_REG) && (pend_q[rd_a[p]] != '0)) begin
`ifdef REGFILE_WB_SCHED_FWD_EN
        if (rf_we && (rf_waddr == rd_a[p]) && (pend_q[rd_a[p]] == 2'd1)) fwd_c[p] = 1'b1;
        else                                                            hazard_c  = 1'b1;
`else
        hazard_c = 1'b1;
`endif
      end
    end
  end

  assign hazard  = hazard_c;
  assign fwd_hit = fwd_c;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: expected commits queued at stimulus, checked by a monitor.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, lnk_valid, iss_valid;
  logic [3:0]  alu_addr, mem_addr, iss_addr, rd_addr1, rd_addr2, rd_addr3;
  logic [31:0] alu_data, mem_data, lnk_data;
  logic        rf_we, pc_we, stall, hazard, err;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_wdata;
  logic [2:0]  fwd_hit, q_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          pc;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  regfile_wb_sched #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .lnk_valid(lnk_valid), .lnk_data(lnk_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata),
    .stall(stall), .hazard(hazard), .fwd_hit(fwd_hit),
    .q_count(q_count), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic expect_wr(input bit pc, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.pc = pc; e.addr = a; e.data = d;
    expq.push_back(e);
  endtask

  // Advance to just after the next rising edge and clear all requests
  task automatic tick();
    @(posedge clk);
    #1;
    mem_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] a);
    tick();
    iss_valid = 1'b1; iss_addr = a;
    settle();
  endtask

  task automatic triple(input logic [3:0] ma, input logic [31:0] md,
                        input logic [3:0] aa, input logic [31:0] ad, input logic [31:0] ld);
    mem_valid = 1'b1; mem_addr = ma; mem_data = md;
    alu_valid = 1'b1; alu_addr = aa; alu_data = ad;
    lnk_valid = 1'b1; lnk_data = ld;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected commit
  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  ga;
    logic [31:0] gd;
    if (rf_we === 1'b1 || pc_we === 1'b1) begin
      checks++;
      ga = pc_we ? 4'd15 : rf_waddr;
      gd = pc_we ? pc_wdata : rf_wdata;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected actual pc=%0b addr=%0d data=0x%0h expected none t=%0t",
                 pc_we, ga, gd, $time);
      end else begin
        e = expq.pop_front();
        if ((rf_we && pc_we) || (pc_we != e.pc) || (ga != e.addr) || (gd != e.data)) begin
          failures++;
          $display("FAIL wr_commit actual rf_we=%0b pc_we=%0b addr=%0d data=0x%0h expected pc=%0b addr=%0d data=0x%0h t=%0t",
                   rf_we, pc_we, ga, gd, e.pc, e.addr, e.data, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0; iss_valid = 1'b0;
    mem_addr = '0; alu_addr = '0; iss_addr = '0; mem_data = '0; alu_data = '0; lnk_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; rd_addr3 = '0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_hazard", 32'(hazard), 0);
    chk("rst_fwd_hit", 32'(fwd_hit), 0);
    chk("rst_q_count", 32'(q_count), 0);
    tick(); reset = 1'b0; settle();
    chk("rst_err", 32'(err), 0);

    // Single ALU write, zero latency
    issue(4'd3);
    tick();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
    expect_wr(1'b0, 4'd3, 32'h11);
    settle();
    chk("single_q_count", 32'(q_count), 0);
    tick(); settle();
    chk("single_q_after", 32'(q_count), 0);

    // Triple collision drains R5, R6, R14
    issue(4'd5); issue(4'd6); issue(4'd14);
    tick();
    triple(4'd5, 32'hA, 4'd6, 32'hB, 32'hC);
    expect_wr(1'b0, 4'd5, 32'hA);
    expect_wr(1'b0, 4'd6, 32'hB);
    expect_wr(1'b0, 4'd14, 32'hC);
    settle();
    tick(); settle(); chk("tri_q_2", 32'(q_count), 2);
    tick(); settle(); chk("tri_q_1", 32'(q_count), 1);
    tick(); settle(); chk("tri_q_0", 32'(q_count), 0);

    // PC write
    tick();
    alu_valid = 1'b1; alu_addr = 4'd15; alu_data = 32'h100;
    expect_wr(1'b1, 4'd15, 32'h100);
    settle();
    chk("pc_rf_we", 32'(rf_we), 0);

    // Scoreboard hazard on R7
    issue(4'd7);
    tick(); rd_addr1 = 4'd7; settle();
    chk("sb_hazard_pend", 32'(hazard), 1);
    tick();
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h77;
    expect_wr(1'b0, 4'd7, 32'h77);
    settle();
`ifdef REGFILE_WB_SCHED_FWD_EN
    chk("sb_fwd_hit", 32'(fwd_hit), 1);
    chk("sb_hazard_commit", 32'(hazard), 0);
`else
    chk("sb_fwd_hit", 32'(fwd_hit), 0);
    chk("sb_hazard_commit", 32'(hazard), 1);
`endif
    tick(); settle();
    chk("sb_hazard_clear", 32'(hazard), 0);
    chk("sb_err_clean", 32'(err), 0);
    rd_addr1 = 4'd0;

    // Overflow: fill to stall, then a dropped request
    issue(4'd5); issue(4'd6); issue(4'd14);
    issue(4'd5); issue(4'd6); issue(4'd14);
    tick();
    triple(4'd5, 32'h51, 4'd6, 32'h61, 32'h71);
    expect_wr(1'b0, 4'd5, 32'h51);
    expect_wr(1'b0, 4'd6, 32'h61);
    expect_wr(1'b0, 4'd14, 32'h71);
    settle();
    chk("ovf_err_pre", 32'(err), 0);
    tick();
    triple(4'd5, 32'h52, 4'd6, 32'h62, 32'h72);
    expect_wr(1'b0, 4'd5, 32'h52);
    expect_wr(1'b0, 4'd6, 32'h62);
    expect_wr(1'b0, 4'd14, 32'h72);
    settle();
    chk("ovf_stall0", 32'(stall), 0);
    chk("ovf_q_2", 32'(q_count), 2);
    tick();
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'hDEAD;
    settle();
    chk("ovf_stall1", 32'(stall), 1);
    chk("ovf_q_4", 32'(q_count), 4);
    tick(); settle();
    chk("ovf_err", 32'(err), 1);
    chk("ovf_q_3", 32'(q_count), 3);
    tick(); settle();
    tick(); settle();
    tick(); settle();
    chk("ovf_q_drained", 32'(q_count), 0);

    // Reset mid-burst with three queued entries
    issue(4'd2);
    tick();
    triple(4'd1, 32'h1, 4'd4, 32'h4, 32'hE);
    expect_wr(1'b0, 4'd1, 32'h1);
    settle();
    tick();
    mem_valid = 1'b1; mem_addr = 4'd8; mem_data = 32'h8;
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'h9;
    expect_wr(1'b0, 4'd4, 32'h4);
    settle();
    chk("mid_q_2", 32'(q_count), 2);
    tick(); reset = 1'b1; settle();
    chk("mid_q_3", 32'(q_count), 3);
    chk("mid_stall", 32'(stall), 1);
    chk("mid_rf_we", 32'(rf_we), 0);
    chk("mid_pc_we", 32'(pc_we), 0);
    tick(); reset = 1'b0; rd_addr1 = 4'd2; settle();
    chk("post_q_count", 32'(q_count), 0);
    chk("post_rf_we", 32'(rf_we), 0);
    chk("post_hazard", 32'(hazard), 0);
    chk("post_err", 32'(err), 0);
    chk("post_stall", 32'(stall), 0);
    rd_addr1 = 4'd0;

    // Pending counter saturation on R8
    issue(4'd8); issue(4'd8); issue(4'd8);
    tick(); rd_addr2 = 4'd8; settle();
    chk("sat_err_pre", 32'(err), 0);
    chk("sat_hazard", 32'(hazard), 1);
    issue(4'd8);
    tick(); settle();
    chk("sat_err", 32'(err), 1);

    tick(); settle();
    chk("sb_empty", 32'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of write-queue entries.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result write request.
- alu_addr  in  4  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load writeback request.
- mem_addr  in  4  load destination register.
- mem_data  in  32  load data.
- lnk_valid  in  1  link write request; destination is fixed at R14.
- lnk_data  in  32  return address (PC+4).
- iss_valid  in  1  decode issues an instruction with a register destination.
- iss_addr  in  4  destination of the issued instruction.
- rd_addr1, rd_addr2, rd_addr3  in  4 each  register file read addresses.
- rf_we  out  1  register file write enable.
- rf_waddr  out  4  register file write address.
- rf_wdata  out  32  register file write data.
- pc_we  out  1  PC register write enable.
- pc_wdata  out  32  PC register write data.
- stall  out  1  requesters and issue SHALL hold off.
- hazard  out  1  a read operand has a pending write.
- fwd_hit  out  3  per read port: operand satisfied by this cycle's write.
- q_count  out  3  current queue occupancy.
- err  out  1  sticky protocol error.

Function
REQ-003 SHALL commit at most one write per cycle. Priority: queue head, then mem, then alu, then lnk.
REQ-004 SHALL enqueue every valid request that is not granted, in the order mem, alu, lnk, in the same cycle.
REQ-005 SHALL grant a direct (non-queued) request only when the queue is empty, so that write order is preserved.
REQ-006 SHALL route a grant to address 15 to pc_we/pc_wdata with rf_we=0. All other addresses SHALL drive rf_we/rf_waddr/rf_wdata.
REQ-007 SHALL make write outputs combinational from the current cycle's grant, giving zero-cycle latency from request to write.
REQ-008 SHALL assert stall when q_count >= DEPTH-1. This bound holds because up to 3 requests arrive per cycle and 1 is retired.
REQ-009 SHALL set err, and drop the excess requests, when a valid request or iss_valid is seen while stall=1, or when the queue would overflow.
REQ-010 SHALL keep a 2-bit pending counter per register 0-14; R15 has no counter.
- iss_valid increments the counter for iss_addr.
- A commit to that address decrements it.
- A simultaneous issue and commit to the same address leaves it unchanged.
REQ-011 SHALL set err, with the counter saturated at 3, when an issue targets a counter already at 3. SHALL set err, with the counter held at 0, when a commit targets a counter at 0.
REQ-012 SHALL assert hazard when any rd_addrN != 15 has a nonzero counter, subject to REQ-017.
REQ-013 SHALL keep q_count exact at all times, including simultaneous enqueue and dequeue and wrap-around of the read and write pointers.

Reset
REQ-014 SHALL, on reset:
- empty the queue;
- clear all counters;
- clear err;
- drive rf_we=0, pc_we=0, stall=0, hazard=0, fwd_hit=0, q_count=0.
REQ-015 SHALL treat reset asserted mid-burst as aborting all queued writes, with no write committed in the reset cycle.

Configuration
REQ-016 SHALL gate forwarding with macro REGFILE_WB_SCHED_FWD_EN.
REQ-017 With REGFILE_WB_SCHED_FWD_EN defined: a read port whose address equals this cycle's committed rf_waddr, and whose counter is 1, SHALL set its fwd_hit bit and SHALL not contribute to hazard.
REQ-018 Without REGFILE_WB_SCHED_FWD_EN: fwd_hit SHALL be tied to 0, and hazard SHALL depend only on the counters.

Structure
REQ-019 SHALL place the following in package regfile_wb_sched_pkg:
- the queue entry typedef (addr 4b, data 32b);
- the source enum (SRC_MEM, SRC_ALU, SRC_LNK);
- the constant LINK_REG=14;
- the constant PC_REG=15.
REQ-020 SHALL implement the queue as sub-module regfile_wb_sched_fifo: DEPTH entries, pointer-based, up to 3 pushes and 1 pop per cycle.

Verification
REQ-021 SHALL pass these directed scenarios:
- Single request: alu_valid, addr 3, data 0x11, empty queue -> same cycle rf_we=1, rf_waddr=3, rf_wdata=0x11, q_count stays 0.
- Triple collision: mem(5, 0xA), alu(6, 0xB) and lnk(0xC) in one cycle -> commits in order R5, R6, R14 on consecutive cycles; q_count goes 2, 1, 0.
- PC write: alu addr 15, data 0x100 -> pc_we=1, pc_wdata=0x100, rf_we=0.
- Scoreboard: iss R7, then rd_addr1=7 -> hazard=1. After the R7 commit, hazard=0. With FWD_EN, fwd_hit[0]=1 and hazard=0 in the commit cycle.
- Overflow: hold triple collisions until stall=1, then assert alu_valid -> err=1, request dropped, queue contents intact.
- Reset mid-burst: reset with q_count=3 -> next cycle q_count=0, rf_we=0, all counters clear.
